counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
//
// PURPOSE
//   Programmable interval-timer controller wrapping a free-running up-counter.
//   Sequences the count: start/stop/hold, one-shot or periodic mode, terminal-tick
//   generation at a programmed period. Sits between a control register block and
//   any logic needing timed events (timeouts, periodic strobes).
//
// PARAMETERS
//   WIDTH   4   counter / period width in bits; max period 2**WIDTH-1
//
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      1-cycle request: latch period/mode, (re)start count from 0
//   stop    in   1      abort: return to IDLE, clear count/done
//   hold    in   1      level: freeze count while RUN (no state change)
//   mode    in   1      0 = one-shot, 1 = periodic; sampled with start only
//   period  in   WIDTH  terminal value P; sampled with start only
//   count   out  WIDTH  current count value
//   busy    out  1      high while in RUN
//   tick    out  1      1-cycle registered pulse at each terminal count
//   done    out  1      level, one-shot completed; cleared by start or stop
//   err     out  1      1-cycle pulse: start rejected because period == 0
//
// BEHAVIOUR
//   - All outputs registered. Reset (async, any time incl. mid-RUN): state IDLE,
//     count=0, busy=0, tick=0, done=0, err=0, latched period/mode=0.
//   - States: IDLE, RUN, DONE.
//   - Priority per edge: stop > start > hold > increment.
//   - stop (any state): -> IDLE, count<=0, busy<=0, done<=0, tick<=0.
//   - start, period!=0 (any state): period_q<=period, mode_q<=mode, count<=0,
//     done<=0, busy<=1, -> RUN. Start while RUN = restart; no tick that edge
//     even if count==period_q.
//   - start, period==0: err<=1 for one cycle; state/count/latched values unchanged.
//   - RUN, hold=1: count, state frozen; tick<=0.
//   - RUN, hold=0, count!=period_q: count<=count+1, tick<=0.
//   - RUN, hold=0, count==period_q: count<=0, tick<=1;
//       mode_q=0 -> DONE, busy<=0, done<=1;  mode_q=1 -> stay RUN.
//   - Result: tick every P+1 un-held cycles; first tick P+1 edges after the
//     edge sampling start. count never exceeds period_q; P=2**WIDTH-1 wraps to 0.
//   - DONE: count holds 0, done stays 1 until start or stop. hold ignored
//     outside RUN. tick and err are never high for more than one cycle.
//
// STRUCTURE
//   - Package counter_ctrl_pkg: state enum {ST_IDLE, ST_RUN, ST_DONE};
//     constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
//   - One sub-module: counter_en -- WIDTH-bit up-counter, async active-low reset,
//     sync clear and enable inputs; FSM drives clear/enable, compares count.
//   - FSM, period/mode latches, tick/done/err registers in the top level.
//
// TESTING (WIDTH=4)
//   1. One-shot P=3, start at edge 0 -> count 0,1,2,3; edge 4: tick=1 one cycle,
//      done=1, busy=0, count=0; done stays 1 for 10 further cycles.
//   2. Periodic P=2 for 12 edges after start -> tick every 3rd edge (4 ticks),
//      busy constant 1, done 0.
//   3. Periodic P=5, hold=1 for 5 cycles at count=2 -> count stays 2, no tick;
//      first tick 5 edges later than unheld run (edge 11 instead of edge 6).
//   4. P=15 periodic -> count 0..15 then 0, tick every 16 edges, no overflow.
//   5. start with P=0 while RUN P=4 -> err one cycle, count continues, period 4
//      kept; start+stop same edge -> IDLE, count 0, busy 0.
//   6. rst_n low mid-RUN at count=3 -> all outputs 0 without clock edge; after
//      release, idle until start; restart mid-RUN at count==P -> no tick, count 0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the interval-timer controller.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_counter_en.sv
// WIDTH-bit up-counter with synchronous clear (dominant) and count enable.
module counter_en #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : counter_en

// File: rtl/counter_ctrl.sv
// Interval-timer controller: sequences a counter_en instance through
// IDLE/RUN/DONE, producing terminal ticks in one-shot or periodic mode.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             mode,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic             err
);

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             mode_q,   mode_d;
   logic             tick_q,   tick_d;
   logic             done_q,   done_d;
   logic             err_q,    err_d;
   logic             cnt_clr;
   logic             cnt_en;
   logic [WIDTH-1:0] cnt_val;

   counter_en #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (cnt_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         period_q <= '0;
         mode_q   <= MODE_ONESHOT;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Priority stop > start > hold > increment; a restart never ticks.
   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      mode_d   = mode_q;
      tick_d   = 1'b0;
      done_d   = done_q;
      err_d    = 1'b0;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      if (stop) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
         cnt_clr = 1'b1;
      end else if (start) begin
         if (period != '0) begin
            period_d = period;
            mode_d   = mode;
            done_d   = 1'b0;
            cnt_clr  = 1'b1;
            state_d  = ST_RUN;
         end else begin
            err_d = 1'b1;
         end
      end else if (state_q == ST_RUN && !hold) begin
         if (cnt_val == period_q) begin
            cnt_clr = 1'b1;
            tick_d  = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end else begin
            cnt_en = 1'b1;
         end
      end
   end

   always_comb begin
      busy  = (state_q == ST_RUN);
      count = cnt_val;
      tick  = tick_q;
      done  = done_q;
      err   = err_q;
   end

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Randomized self-checking bench for counter_ctrl against an elapsed-time model.
module tb_counter_ctrl;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             stop;
   logic             hold;
   logic             mode;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tick;
   logic             done;
   logic             err;

   int n_vec;
   int n_err;

   // Model: running flag, un-held edges elapsed since start, latched P/mode.
   bit m_run;
   int m_elapsed;
   int m_p;
   bit m_mode;
   bit m_tick;
   bit m_done;
   bit m_err;

   counter_ctrl #(
      .WIDTH (WIDTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .stop   (stop),
      .hold   (hold),
      .mode   (mode),
      .period (period),
      .count  (count),
      .busy   (busy),
      .tick   (tick),
      .done   (done),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_elapsed = 0; m_p = 0; m_mode = 0;
      m_tick = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_edge(input bit st, input bit sp, input bit hd,
                             input bit md, input int pr);
      m_tick = 0;
      m_err  = 0;
      if (sp) begin
         m_run = 0; m_elapsed = 0; m_done = 0;
      end else if (st) begin
         if (pr != 0) begin
            m_p = pr; m_mode = md; m_run = 1; m_elapsed = 0; m_done = 0;
         end else begin
            m_err = 1;
         end
      end else if (m_run && !hd) begin
         m_elapsed++;
         if (m_elapsed % (m_p + 1) == 0) begin
            m_tick = 1;
            if (!m_mode) begin
               m_run = 0; m_done = 1; m_elapsed = 0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".count"}, int'(count), m_run ? (m_elapsed % (m_p + 1)) : 0);
      check_eq({tag, ".busy"},  int'(busy),  int'(m_run));
      check_eq({tag, ".tick"},  int'(tick),  int'(m_tick));
      check_eq({tag, ".done"},  int'(done),  int'(m_done));
      check_eq({tag, ".err"},   int'(err),   int'(m_err));
   endtask

   // Called at a negedge; applies inputs for one rising edge and checks after it.
   task automatic cycle(input string tag, input bit st, input bit sp, input bit hd,
                        input bit md, input int pr);
      start = st; stop = sp; hold = hd; mode = md; period = WIDTH'(pr);
      @(posedge clk);
      model_edge(st, sp, hd, md, pr);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      start = 0; stop = 0; hold = 0; mode = 0; period = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // One-shot P=3: counts 0..3, tick/done on the fourth edge, done persists.
      cycle("os3", 1, 0, 0, 0, 3);
      idle_cycles("os3", 3);
      check_eq("os3.cnt_at3", int'(count), 3);
      cycle("os3_term", 0, 0, 0, 0, 0);
      check_eq("os3.tick", int'(tick), 1);
      check_eq("os3.done", int'(done), 1);
      idle_cycles("os3_hold", 10);
      check_eq("os3.done_kept", int'(done), 1);

      // Periodic P=2 for 12 edges.
      cycle("per2", 1, 0, 0, 1, 2);
      idle_cycles("per2", 12);

      // Periodic P=5 with a 5-cycle hold at count 2.
      cycle("hold5", 1, 0, 0, 1, 5);
      idle_cycles("hold5", 2);
      for (int i = 0; i < 5; i++) cycle("hold5_h", 0, 0, 1, 0, 0);
      check_eq("hold5.frozen", int'(count), 2);
      idle_cycles("hold5", 5);

      // Full-range period wraps to 0 without overflow.
      cycle("p15", 1, 0, 0, 1, 15);
      idle_cycles("p15", 33);

      // Zero-period start rejected mid-run, then start+stop together.
      cycle("p4", 1, 0, 0, 1, 4);
      idle_cycles("p4", 2);
      cycle("p4_err", 1, 0, 0, 0, 0);
      check_eq("p4.err", int'(err), 1);
      idle_cycles("p4", 3);
      cycle("ststop", 1, 1, 0, 1, 4);
      check_eq("ststop.busy", int'(busy), 0);

      // Async reset mid-run at count 3, observed without a clock edge.
      cycle("ar", 1, 0, 0, 1, 6);
      idle_cycles("ar", 3);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      check_eq("async_rst.count", int'(count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      idle_cycles("post_rst", 3);

      // Restart exactly at count == P: no tick, count back to 0.
      cycle("rs", 1, 0, 0, 1, 3);
      idle_cycles("rs", 3);
      cycle("rs_restart", 1, 0, 0, 1, 3);
      check_eq("rs.tick", int'(tick), 0);
      check_eq("rs.count", int'(count), 0);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         bit st, sp, hd, md;
         int pr;
         st = ($urandom_range(0, 99) < 6);
         sp = ($urandom_range(0, 99) < 2);
         hd = ($urandom_range(0, 99) < 15);
         md = 1'($urandom_range(0, 1));
         pr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
         cycle("rand", st, sp, hd, md, pr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, want completion");
      $fatal(1, "timeout");
   end

endmodule : tb_counter_ctrl
